bf_bram_ctrl: RTL and testbench
===============================

Name: bf_bram_ctrl

Overview:
- Initiator/controller side of the 1-bit-wide, 2^17-deep true dual-port Bloom-filter bit array.
- Accepts hashed-bit insert requests and query requests from the filter datapath, and drives both RAM ports.
  - Port A handles inserts.
  - Port B handles queries.
- Returns query hits at fixed latency and provides a full-array clear sweep.
- Sits between the hash/index generator and the BRAM instance.

Parameters:
- ADDR_W, 17, bit-index width; array depth is 2**ADDR_W.
- RD_LAT, 2, RAM read latency in cycles from address presented to q valid (1..4).
- TAG_W, 8, query tag width, returned unmodified with the response.

Ports:
- clock  in  1  single clock for the block and the RAM.
- reset  in  1  asynchronous, active-high reset.
- ins_valid  in  1  insert request valid.
- ins_ready  out  1  insert accepted when ins_valid && ins_ready.
- ins_addr  in  ADDR_W  bit index to set.
- qry_valid  in  1  query request valid.
- qry_ready  out  1  query accepted when qry_valid && qry_ready.
- qry_addr  in  ADDR_W  bit index to test.
- qry_tag  in  TAG_W  query tag.
- rsp_valid  out  1  query response valid, one-cycle pulse; no backpressure.
- rsp_hit  out  1  stored bit value, or forwarded 1.
- rsp_tag  out  TAG_W  tag of the responding query.
- clr_req  in  1  level request to zero the whole array.
- clr_busy  out  1  high from clear acceptance until the sweep completes.
- clr_done  out  1  one-cycle pulse after the last clear write.
- address_a  out  ADDR_W  RAM port A address.
- data_a  out  1  RAM port A write data.
- wren_a  out  1  RAM port A write enable.
- q_a  in  1  RAM port A read data; unused, tied off internally.
- address_b  out  ADDR_W  RAM port B address.
- data_b  out  1  RAM port B write data.
- wren_b  out  1  RAM port B write enable.
- q_b  in  1  RAM port B read data.

Behaviour:
- Reset values:
  - all outputs 0;
  - FSM in IDLE;
  - query pipeline valid bits cleared, so in-flight responses are dropped;
  - sweep counter 0.
- FSM states IDLE, DRAIN, CLEAR.
- IDLE:
  - ins_ready = qry_ready = !clr_req.
  - Insert accepted: same cycle drives address_a=ins_addr, data_a=1, wren_a=1 (combinational); otherwise wren_a=0.
  - Query accepted: same cycle drives address_b=qry_addr, wren_b=0.
  - Query pipeline: an RD_LAT-deep shift register of {valid, tag, fwd}.
  - rsp_valid/rsp_tag come from the last stage; rsp_hit = q_b | fwd.
  - Response appears exactly RD_LAT cycles after acceptance.
  - Back-to-back queries give one response per cycle.
  - fwd=1 when an insert and a query to the same address are accepted in the same cycle; mixed-port read-during-write returns old data.
  - Insert accepted in cycle N is visible to a query accepted in cycle N+1 or later; no further forwarding is needed.
  - clr_req=1 → DRAIN, with clr_busy=1 from the next cycle.
- DRAIN:
  - ready outputs 0 and no new RAM access.
  - When the pipeline is empty (all valid bits 0) → CLEAR, counter=0.
  - If the pipeline is already empty on entry, DRAIN lasts one cycle.
- CLEAR:
  - Each cycle writes 0 on both ports: address_a={cnt,0}, address_b={cnt,1}, wren_a=wren_b=1, data=0.
  - cnt is ADDR_W-1 bits wide, increments each cycle, and takes 2**(ADDR_W-1) cycles (65536 at default).
  - On the cycle cnt wraps from all-ones, pulse clr_done the next cycle, drop clr_busy, and go to IDLE.
  - clr_req is ignored during DRAIN/CLEAR.
  - If clr_req is still high on return to IDLE, a new clear starts; the requester must deassert on clr_done.
- rsp_valid is never asserted during CLEAR.
- Reset asserted mid-CLEAR: the sweep aborts, array contents are unspecified, and the requester must re-issue the clear.

Decomposition:
- Shared package bf_pkg holds:
  - BF_ADDR_W=17, BF_RD_LAT=2;
  - typedef bf_addr_t;
  - enum bf_ctrl_state_t {IDLE, DRAIN, CLEAR}.
- One natural sub-module, bf_qry_pipe: the RD_LAT-stage valid/tag/fwd shift register with an empty flag.

Test Plan:
- Insert addr 0x1ABCD, then query 0x1ABCD two cycles later → rsp_valid exactly RD_LAT=2 cycles after query acceptance, rsp_hit=1, tag echoed.
- Query untouched addr 0x00010 after reset-time clear → rsp_hit=0.
- Insert and query 0x0F0F0 in the same cycle → rsp_hit=1 (fwd path).
- Stream 16 back-to-back queries with tags 0..15 over mixed set/unset addresses → 16 consecutive rsp_valid cycles, tags in order, hits matching the model.
- Three queries in flight, then assert clr_req → all 3 responses delivered, then wren_a=wren_b=1 for 65536 cycles, clr_done pulses once, and a subsequent query to a previously inserted addr returns hit=0.
- Assert reset at cycle 100 of a clear → all outputs 0 the same cycle, FSM in IDLE, clr_busy=0, no rsp_valid after release.

Source files
------------

// File: rtl/bf_pkg.sv
// Shared constants and types for the Bloom-filter bit-array controller.
package bf_pkg;
  localparam int BF_ADDR_W = 17;
  localparam int BF_RD_LAT = 2;
  localparam int BF_TAG_W  = 8;

  typedef logic [BF_ADDR_W-1:0] bf_addr_t;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    CLEAR
  } bf_ctrl_state_t;
endpackage

// File: rtl/bf_bram_ctrl_if.sv
// Request/response and RAM-port bundle between the filter datapath, the controller and the BRAM.
interface bf_bram_ctrl_if
  import bf_pkg::*;
#(
  parameter int ADDR_W = BF_ADDR_W,
  parameter int TAG_W  = BF_TAG_W
);
  // A request transfers in the cycle where valid && ready; valid may not wait on ready.
  // rsp_valid is a one-cycle pulse with no backpressure.
  logic              ins_valid;
  logic              ins_ready;
  logic [ADDR_W-1:0] ins_addr;
  logic              qry_valid;
  logic              qry_ready;
  logic [ADDR_W-1:0] qry_addr;
  logic [TAG_W-1:0]  qry_tag;
  logic              rsp_valid;
  logic              rsp_hit;
  logic [TAG_W-1:0]  rsp_tag;
  logic              clr_req;
  logic              clr_busy;
  logic              clr_done;
  logic [ADDR_W-1:0] address_a;
  logic              data_a;
  logic              wren_a;
  logic              q_a;
  logic [ADDR_W-1:0] address_b;
  logic              data_b;
  logic              wren_b;
  logic              q_b;

  // master: datapath plus RAM read data; slave: the controller.
  modport master (
    output ins_valid, ins_addr, qry_valid, qry_addr, qry_tag, clr_req, q_a, q_b,
    input  ins_ready, qry_ready, rsp_valid, rsp_hit, rsp_tag, clr_busy, clr_done,
           address_a, data_a, wren_a, address_b, data_b, wren_b
  );

  modport slave (
    input  ins_valid, ins_addr, qry_valid, qry_addr, qry_tag, clr_req, q_a, q_b,
    output ins_ready, qry_ready, rsp_valid, rsp_hit, rsp_tag, clr_busy, clr_done,
           address_a, data_a, wren_a, address_b, data_b, wren_b
  );
endinterface

// File: rtl/bf_qry_pipe.sv
// Query side-band shift register matching the RAM read latency, with an all-empty flag.
module bf_qry_pipe #(
  parameter int RD_LAT = 2,
  parameter int TAG_W  = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             in_fwd,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_fwd,
  output logic             empty
);
  logic [RD_LAT-1:0] v;
  logic [RD_LAT-1:0] f;
  logic [TAG_W-1:0]  t [RD_LAT];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v <= '0;
      f <= '0;
      for (int i = 0; i < RD_LAT; i++) t[i] <= '0;
    end else begin
      v[0] <= in_valid;
      f[0] <= in_fwd;
      t[0] <= in_tag;
      for (int i = 1; i < RD_LAT; i++) begin
        v[i] <= v[i-1];
        f[i] <= f[i-1];
        t[i] <= t[i-1];
      end
    end
  end

  assign out_valid = v[RD_LAT-1];
  assign out_fwd   = f[RD_LAT-1];
  assign out_tag   = t[RD_LAT-1];
  assign empty     = ~|v;
endmodule

// File: rtl/bf_bram_ctrl.sv
// Bloom-filter bit-array controller: port A sets bits, port B answers queries,
// and a DRAIN/CLEAR sweep zeroes two bits per cycle using both ports.
module bf_bram_ctrl
  import bf_pkg::*;
#(
  parameter int ADDR_W = BF_ADDR_W,
  parameter int RD_LAT = BF_RD_LAT,
  parameter int TAG_W  = BF_TAG_W
) (
  input  logic           clock,
  input  logic           reset,
  bf_bram_ctrl_if.slave  bus,
  output bf_ctrl_state_t dbg_state
);
  bf_ctrl_state_t    state;
  logic [ADDR_W-2:0] cnt;
  logic              clr_busy_r;
  logic              clr_done_r;
  logic              idle_open;
  logic              ins_fire;
  logic              qry_fire;
  logic              fwd;
  logic              p_valid;
  logic              p_fwd;
  logic [TAG_W-1:0]  p_tag;
  logic              p_empty;
  logic              unused_q_a;

  assign unused_q_a = bus.q_a;

  // Reset is folded in so every combinational output reads 0 while reset is held.
  assign idle_open = (state == IDLE) && !bus.clr_req && !reset;
  assign ins_fire  = idle_open && bus.ins_valid;
  assign qry_fire  = idle_open && bus.qry_valid;
  // The RAM returns old data on a same-cycle mixed-port collision, so flag it.
  assign fwd       = ins_fire && qry_fire && (bus.ins_addr == bus.qry_addr);

  bf_qry_pipe #(.RD_LAT(RD_LAT), .TAG_W(TAG_W)) u_qry_pipe (
    .clock    (clock),
    .reset    (reset),
    .in_valid (qry_fire),
    .in_tag   (bus.qry_tag),
    .in_fwd   (fwd),
    .out_valid(p_valid),
    .out_tag  (p_tag),
    .out_fwd  (p_fwd),
    .empty    (p_empty)
  );

  always_comb begin
    bus.ins_ready = idle_open;
    bus.qry_ready = idle_open;
    bus.address_a = '0;
    bus.data_a    = 1'b0;
    bus.wren_a    = 1'b0;
    bus.address_b = '0;
    bus.data_b    = 1'b0;
    bus.wren_b    = 1'b0;
    if (ins_fire) begin
      bus.address_a = bus.ins_addr;
      bus.data_a    = 1'b1;
      bus.wren_a    = 1'b1;
    end
    if (qry_fire) begin
      bus.address_b = bus.qry_addr;
    end
    if (state == CLEAR && !reset) begin
      bus.address_a = {cnt, 1'b0};
      bus.address_b = {cnt, 1'b1};
      bus.wren_a    = 1'b1;
      bus.wren_b    = 1'b1;
    end
  end

  assign bus.rsp_valid = p_valid;
  assign bus.rsp_hit   = p_valid & (bus.q_b | p_fwd);
  assign bus.rsp_tag   = p_valid ? p_tag : '0;
  assign bus.clr_busy  = clr_busy_r;
  assign bus.clr_done  = clr_done_r;
  assign dbg_state     = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      clr_busy_r <= 1'b0;
      clr_done_r <= 1'b0;
    end else begin
      clr_done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.clr_req) begin
            state      <= DRAIN;
            clr_busy_r <= 1'b1;
          end
        end
        DRAIN: begin
          if (p_empty) begin
            state <= CLEAR;
            cnt   <= '0;
          end
        end
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (&cnt) begin
            state      <= IDLE;
            clr_busy_r <= 1'b0;
            clr_done_r <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bf_bram_ctrl.sv
// Directed bench for bf_bram_ctrl with a behavioural 2-cycle dual-port bit RAM.
module tb_bf_bram_ctrl;
  import bf_pkg::*;

  localparam int AW  = BF_ADDR_W;
  localparam int LAT = BF_RD_LAT;
  localparam int TW  = BF_TAG_W;
  localparam int QW  = 32 + TW + 1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  bf_bram_ctrl_if #(.ADDR_W(AW), .TAG_W(TW)) bus ();
  bf_ctrl_state_t dbg_state;

  bf_bram_ctrl #(.ADDR_W(AW), .RD_LAT(LAT), .TAG_W(TW)) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  // RAM model: read registered then delayed one stage; same-cycle write is not seen.
  bit mem [0:(1<<AW)-1];
  bit rb1, rb2, ra1;
  always @(posedge clock) begin
    rb1 <= mem[bus.address_b];
    rb2 <= rb1;
    ra1 <= mem[bus.address_a];
    if (bus.wren_a) mem[bus.address_a] <= bus.data_a;
    if (bus.wren_b) mem[bus.address_b] <= bus.data_b;
  end
  assign bus.q_b = rb2;
  assign bus.q_a = ra1;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [QW-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    logic [QW-1:0] e;
    if (bus.rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_cycle", cyc, e[QW-1 -: 32]);
        check("rsp_tag", bus.rsp_tag, e[TW:1]);
        check("rsp_hit", bus.rsp_hit, e[0]);
      end
    end
  end

  // One cycle of stimulus, entered and left at posedge+1.
  task automatic drive(input bit iv, input int ia, input bit qv, input int qa,
                       input int tag, input bit exp_hit);
    bus.ins_valid = iv;
    bus.ins_addr  = AW'(ia);
    bus.qry_valid = qv;
    bus.qry_addr  = AW'(qa);
    bus.qry_tag   = TW'(tag);
    @(negedge clock);
    if (iv) check("ins_ready", bus.ins_ready, 1);
    if (qv) begin
      check("qry_ready", bus.qry_ready, 1);
      exp_q.push_back({32'(cyc + LAT), TW'(tag), exp_hit});
    end
    @(posedge clock);
    #1;
    bus.ins_valid = 1'b0;
    bus.qry_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_drain();
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < 20) begin
      @(posedge clock);
      #1;
      i++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  task automatic check_zero_outputs();
    check("z_ins_ready", bus.ins_ready, 0);
    check("z_qry_ready", bus.qry_ready, 0);
    check("z_rsp_valid", bus.rsp_valid, 0);
    check("z_rsp_hit", bus.rsp_hit, 0);
    check("z_rsp_tag", bus.rsp_tag, 0);
    check("z_clr_busy", bus.clr_busy, 0);
    check("z_clr_done", bus.clr_done, 0);
    check("z_address_a", bus.address_a, 0);
    check("z_wren_a", bus.wren_a, 0);
    check("z_data_a", bus.data_a, 0);
    check("z_address_b", bus.address_b, 0);
    check("z_wren_b", bus.wren_b, 0);
    check("z_data_b", bus.data_b, 0);
    check("z_state", dbg_state, IDLE);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int sweep, dones, nz, cnt100;
    bit seen_busy;
    logic [AW-1:0] last_a, last_b;
    int sa [16] = '{'h1ABCD, 'h00002, 'h0F0F0, 'h00001, 'h10000, 'h00010, 'h1ABCC, 'h1ABCD,
                    'h00000, 'h1FFFF, 'h0F0F1, 'h10000, 'h00003, 'h00001, 'h0F0F0, 'h08000};
    bit sh [16] = '{1, 0, 1, 1, 1, 0, 0, 1, 0, 0, 0, 1, 0, 1, 1, 0};

    bus.ins_valid = 1'b0;
    bus.ins_addr  = '0;
    bus.qry_valid = 1'b0;
    bus.qry_addr  = '0;
    bus.qry_tag   = '0;
    bus.clr_req   = 1'b0;
    for (int i = 0; i < (1 << AW); i++) mem[i] <= 1'($urandom_range(0, 1));

    repeat (3) @(posedge clock);
    #1;
    check_zero_outputs();
    reset = 1'b0;

    // Set three bits, query them, then request a clear with those queries in flight.
    drive(1, 'h00123, 0, 0, 0, 0);
    drive(1, 'h1FFFF, 0, 0, 0, 0);
    drive(1, 'h00000, 0, 0, 0, 0);
    drive(0, 0, 1, 'h00123, 1, 1);
    drive(0, 0, 1, 'h1FFFF, 2, 1);
    drive(0, 0, 1, 'h00000, 3, 1);
    bus.clr_req = 1'b1;
    sweep = 0;
    dones = 0;
    seen_busy = 0;
    last_a = '0;
    last_b = '0;
    for (int i = 0; i < 70000 && dones == 0; i++) begin
      @(negedge clock);
      if (bus.clr_busy) seen_busy = 1;
      if (bus.wren_a && bus.wren_b) begin
        if (sweep == 0) begin
          check("clr_first_addr_a", bus.address_a, 'h00000);
          check("clr_first_addr_b", bus.address_b, 'h00001);
          check("clr_data_a", bus.data_a, 0);
          check("clr_data_b", bus.data_b, 0);
          check("clr_ins_ready", bus.ins_ready, 0);
          check("clr_qry_ready", bus.qry_ready, 0);
          check("clr_busy_on", bus.clr_busy, 1);
          check("clr_state", dbg_state, CLEAR);
          check("clr_rsp_before", exp_q.size(), 0);
        end
        last_a = bus.address_a;
        last_b = bus.address_b;
        sweep++;
      end
      if (bus.clr_done) dones++;
      @(posedge clock);
      #1;
      if (seen_busy) bus.clr_req = 1'b0;
    end
    check("clr_sweep_cycles", sweep, 65536);
    check("clr_done_seen", dones, 1);
    check("clr_last_addr_a", last_a, 'h1FFFE);
    check("clr_last_addr_b", last_b, 'h1FFFF);
    check("clr_busy_off", bus.clr_busy, 0);
    check("clr_idle", dbg_state, IDLE);
    idle(4);
    check("clr_no_restart", bus.clr_busy, 0);
    check("clr_done_once", bus.clr_done, 0);
    nz = 0;
    for (int i = 0; i < (1 << AW); i++) if (mem[i]) nz++;
    check("ram_all_zero", nz, 0);

    drive(0, 0, 1, 'h00123, 4, 0);
    drive(0, 0, 1, 'h00010, 5, 0);
    wait_drain();

    drive(1, 'h1ABCD, 0, 0, 0, 0);
    idle(1);
    drive(0, 0, 1, 'h1ABCD, 'hA5, 1);
    wait_drain();

    drive(1, 'h0F0F0, 1, 'h0F0F0, 'h3C, 1);
    wait_drain();
    drive(1, 'h00001, 1, 'h00002, 'h77, 0);
    drive(1, 'h10000, 0, 0, 0, 0);
    wait_drain();

    for (int i = 0; i < 16; i++) drive(0, 0, 1, sa[i], i, sh[i]);
    wait_drain();

    // A query in flight when reset hits must never respond.
    bus.qry_valid = 1'b1;
    bus.qry_addr  = AW'('h1ABCD);
    bus.qry_tag   = TW'('h99);
    @(negedge clock);
    check("inflight_ready", bus.qry_ready, 1);
    @(posedge clock);
    #1;
    bus.qry_valid = 1'b0;
    reset = 1'b1;
    #1;
    check_zero_outputs();
    idle(2);
    reset = 1'b0;
    idle(5);

    // Abort a sweep after 100 clear cycles.
    bus.clr_req = 1'b1;
    cnt100 = 0;
    seen_busy = 0;
    for (int i = 0; i < 300 && cnt100 < 100; i++) begin
      @(negedge clock);
      if (bus.clr_busy) seen_busy = 1;
      if (bus.wren_a && bus.wren_b) cnt100++;
      @(posedge clock);
      #1;
      if (seen_busy) bus.clr_req = 1'b0;
    end
    check("abort_reached", cnt100, 100);
    check("abort_busy_pre", bus.clr_busy, 1);
    reset = 1'b1;
    #1;
    check_zero_outputs();
    idle(2);
    reset = 1'b0;
    idle(5);
    check("abort_busy_post", bus.clr_busy, 0);
    check("abort_wren_post", bus.wren_a | bus.wren_b, 0);
    check("abort_state_post", dbg_state, IDLE);

    drive(1, 'h05555, 0, 0, 0, 0);
    drive(0, 0, 1, 'h05555, 'h42, 1);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
